out_bank_streamer: RTL and testbench
====================================

Name: out_bank_streamer

Overview:
- Parametrised successor to the fixed two-bank byte readout mux.
- Selects one of NUM_BANKS result banks by proj_sel. Each bank has its own valid bit width.
- Streaming mode: snapshots the selected bank and serialises it LSB-byte-first over an 8-bit valid/ready interface, with last/done/abort/error signalling.
- Random-access mode: keeps the legacy single-byte read (rd_en/byte_sel) for existing host firmware.
- Sits between the project result banks and the host-side 8-bit readout bus.

Parameters:
- NUM_BANKS, 3, number of banks on bank_data.
- BANK_W, 32, physical width per bank slice on bank_data; legal range 8..64.
- BANK_BITS, 24'h10_0A_20, packed 8-bit fields giving valid bits per bank; field i = bank i, so bank0=32, bank1=10, bank2=16. Each field must be in 1..BANK_W.
- SEL_W, 2, width of proj_sel.
- BSEL_W, 3, width of byte_sel; must satisfy 2^BSEL_W >= ceil(BANK_W/8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- bank_data  in  NUM_BANKS*BANK_W  bank i occupies bits [i*BANK_W +: BANK_W].
- proj_sel  in  SEL_W  bank select, sampled on start or rd_en.
- start  in  1  begin streaming the selected bank (IDLE only).
- abort  in  1  terminate an active stream.
- out_ready  in  1  downstream accepts data_out this cycle.
- rd_en  in  1  legacy random-access byte read (IDLE only).
- byte_sel  in  BSEL_W  byte index for rd_en.
- data_out  out  8  stream byte or random-access byte.
- out_valid  out  1  stream byte valid.
- out_last  out  1  current stream byte is the final one.
- rd_valid  out  1  one-cycle pulse: data_out holds a random-access result.
- busy  out  1  high in SEND.
- done  out  1  one-cycle pulse after the last byte is accepted.
- err  out  1  one-cycle pulse when start/rd_en targets proj_sel >= NUM_BANKS.

Behaviour:
- Reset (rst low, async): state=IDLE. data_out=0; out_valid, out_last, rd_valid, busy, done, err=0. Snapshot register and byte counter=0.
- States: IDLE and SEND only.
- Byte count of bank i is NB = ceil(BANK_BITS[i]/8). Snapshot = bank slice with bits >= BANK_BITS[i] forced to 0, so pad bits in the top byte read as 0.
- IDLE, start=1, proj_sel valid:
  - Capture snapshot and NB; counter=0.
  - Next cycle: state=SEND, out_valid=1, busy=1, data_out=byte0, out_last=(NB==1).
  - Latency from start to first valid byte: 1 cycle.
- IDLE, start=1, proj_sel invalid: err=1 for one cycle; stay IDLE; data_out unchanged.
- IDLE, rd_en=1, start=0, proj_sel valid:
  - Next cycle: data_out = snapshot-masked byte[byte_sel] of the live bank; rd_valid=1 for one cycle.
  - If byte_sel >= NB, data_out=8'h00.
- IDLE, rd_en=1, proj_sel invalid: err pulse; data_out holds.
- start and rd_en both high in IDLE: start wins; rd_en is ignored, with no rd_valid.
- SEND:
  - data_out, out_valid and out_last are held stable while out_ready=0.
  - On out_ready=1 with counter<NB-1: counter+1, data_out = next byte, out_last = (counter+1==NB-1).
  - On out_ready=1 with out_last=1: next cycle state=IDLE, out_valid=0, out_last=0, busy=0, done=1 for one cycle; data_out holds the last byte.
- abort=1 in SEND overrides out_ready:
  - Next cycle state=IDLE; out_valid, out_last, busy=0; no done.
  - abort in IDLE has no effect.
- start and rd_en in SEND are ignored, with no err even if proj_sel is invalid. Bank changes during SEND do not affect the stream because the snapshot is held.
- start in the same cycle done is asserted (already IDLE) is accepted normally, so back-to-back streams have a 1-cycle gap.
- rst asserted mid-stream: immediate return to the reset state; no done.

Test Plan:
- Stream bank0 = 32'hDEADBEEF, out_ready=1 constantly.
  - Required: out_valid for 4 consecutive cycles, bytes EF, BE, AD, DE, out_last only on DE, done pulse 1 cycle after DE, busy high for exactly 4 cycles.
- Stream bank1 with slice 32'hFFFF_FEA5 (10 valid bits), with out_ready toggled 1,0,0,1.
  - Required: bytes A5 then 02 (upper pad zeroed); 02 held stable through both stall cycles; out_last on 02.
- Random-access rd_en on bank2 = 16'h1234.
  - byte_sel 0 -> data_out 34 with rd_valid pulse.
  - byte_sel 1 -> 12.
  - byte_sel 2 -> 00.
  - out_valid stays 0 throughout.
- proj_sel=3 with start, then with rd_en.
  - Required: err pulse each time; state stays IDLE; data_out unchanged; no out_valid.
- Abort and reset mid-stream on bank0:
  - Assert abort after the 2nd byte is accepted -> out_valid low next cycle, no done, new start accepted next cycle.
  - Repeat with rst pulled low mid-stream -> all outputs 0 immediately.
- Change bank0 from 32'h11223344 to 32'h55667788 during SEND.
  - Required: output stays 44, 33, 22, 11.

Source files
------------

// File: rtl/out_bank_streamer.sv
// Bank readout: streams a snapshot of one result bank LSB-byte-first over
// valid/ready, or serves legacy single-byte random-access reads.
module out_bank_streamer #(
   parameter int NUM_BANKS = 3,
   parameter int BANK_W    = 32,
   parameter logic [NUM_BANKS*8-1:0] BANK_BITS = 24'h10_0A_20,
   parameter int SEL_W     = 2,
   parameter int BSEL_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_BANKS*BANK_W-1:0] bank_data,
   input  logic [SEL_W-1:0]        proj_sel,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    out_ready,
   input  logic                    rd_en,
   input  logic [BSEL_W-1:0]       byte_sel,
   output logic [7:0]              data_out,
   output logic                    out_valid,
   output logic                    out_last,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int NBYTES = (BANK_W + 7) / 8;
   localparam int PW     = NBYTES * 8;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [PW-1:0]       snap;
   logic [BSEL_W-1:0]   cnt;
   logic [BSEL_W-1:0]   last_idx;

   logic                sel_ok;
   logic [SEL_W-1:0]    sel_idx;
   logic [BANK_W-1:0]   slice;
   logic [7:0]          bits;
   logic [7:0]          nb;
   logic [PW-1:0]       live_pad;
   logic [7:0]          rd_byte;
   logic [BSEL_W-1:0]   cnt_nx;

   // Pad bits above the bank's valid width read back as zero.
   always_comb begin
      sel_ok  = 32'(proj_sel) < NUM_BANKS;
      sel_idx = sel_ok ? proj_sel : '0;
      slice   = bank_data[sel_idx*BANK_W +: BANK_W];
      bits    = BANK_BITS[sel_idx*8 +: 8];
      nb      = (bits + 8'd7) >> 3;
      live_pad = '0;
      for (int j = 0; j < BANK_W; j++)
         live_pad[j] = slice[j] & (j < int'(bits));
      rd_byte = (8'(byte_sel) < nb) ? live_pad[byte_sel*8 +: 8] : 8'h00;
      cnt_nx  = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         snap      <= '0;
         cnt       <= '0;
         last_idx  <= '0;
         data_out  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (sel_ok) begin
                     snap      <= live_pad;
                     last_idx  <= BSEL_W'(nb - 8'd1);
                     cnt       <= '0;
                     state     <= SEND;
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                     data_out  <= live_pad[7:0];
                     out_last  <= (nb == 8'd1);
                  end else begin
                     err <= 1'b1;
                  end
               end else if (rd_en) begin
                  if (sel_ok) begin
                     data_out <= rd_byte;
                     rd_valid <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (abort) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
               end else if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     cnt      <= cnt_nx;
                     data_out <= snap[cnt_nx*8 +: 8];
                     out_last <= (cnt_nx == last_idx);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_out_bank_streamer.sv
// Directed bench for out_bank_streamer: vector table plus
// abort, reset and snapshot sequences.
module tb_out_bank_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic [95:0] bank_data;
   logic [1:0]  proj_sel;
   logic        start, abort, out_ready, rd_en;
   logic [2:0]  byte_sel;
   logic [7:0]  data_out;
   logic        out_valid, out_last, rd_valid, busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   out_bank_streamer dut (
      .clk(clk), .rst(rst), .bank_data(bank_data),
      .proj_sel(proj_sel), .start(start), .abort(abort),
      .out_ready(out_ready), .rd_en(rd_en), .byte_sel(byte_sel),
      .data_out(data_out), .out_valid(out_valid),
      .out_last(out_last), .rd_valid(rd_valid), .busy(busy),
      .done(done), .err(err)
   );

   // exp = {data, valid, last, rd_valid, busy, done, err}
   typedef struct {
      logic       st, rd, ab, rdy;
      logic [1:0] sel;
      logic [2:0] bs;
      logic [13:0] exp;
   } vec_t;

   vec_t v[25];

   function automatic vec_t mk(logic st, logic rd, logic ab, logic rdy,
                               logic [1:0] sel, logic [2:0] bs,
                               logic [7:0] d, logic [5:0] f);
      vec_t r;
      r.st = st; r.rd = rd; r.ab = ab; r.rdy = rdy;
      r.sel = sel; r.bs = bs; r.exp = {d, f};
      return r;
   endfunction

   function automatic logic [13:0] outs();
      return {data_out, out_valid, out_last, rd_valid, busy, done, err};
   endfunction

   task automatic chk(input string name, input logic [13:0] exp);
      logic [13:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got data=%h flags=%b, want data=%h flags=%b",
                  name, got[13:6], got[5:0], exp[13:6], exp[5:0]);
      end
   endtask

   task automatic drive(input logic st, input logic rd, input logic ab,
                        input logic rdy, input logic [1:0] sel,
                        input logic [2:0] bs);
      start = st; rd_en = rd; abort = ab; out_ready = rdy;
      proj_sel = sel; byte_sel = bs;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v[0]  = mk(0,1,0,0,2'd2,3'd0,8'h34,6'b001000);
      v[1]  = mk(0,0,0,0,2'd0,3'd0,8'h34,6'b000000);
      v[2]  = mk(0,1,0,0,2'd2,3'd1,8'h12,6'b001000);
      v[3]  = mk(0,1,0,0,2'd2,3'd2,8'h00,6'b001000);
      v[4]  = mk(0,1,0,0,2'd0,3'd3,8'hDE,6'b001000);
      v[5]  = mk(1,0,0,0,2'd3,3'd0,8'hDE,6'b000001);
      v[6]  = mk(0,1,0,0,2'd3,3'd0,8'hDE,6'b000001);
      v[7]  = mk(0,0,1,0,2'd0,3'd0,8'hDE,6'b000000);
      v[8]  = mk(0,1,0,0,2'd1,3'd1,8'h02,6'b001000);
      v[9]  = mk(0,1,0,0,2'd1,3'd3,8'h00,6'b001000);
      v[10] = mk(1,1,0,0,2'd0,3'd1,8'hEF,6'b100100);
      v[11] = mk(0,1,0,1,2'd3,3'd0,8'hBE,6'b100100);
      v[12] = mk(1,0,0,1,2'd3,3'd0,8'hAD,6'b100100);
      v[13] = mk(0,0,0,1,2'd0,3'd0,8'hDE,6'b110100);
      v[14] = mk(0,0,0,1,2'd0,3'd0,8'hDE,6'b000010);
      v[15] = mk(0,0,0,0,2'd0,3'd0,8'hDE,6'b000000);
      v[16] = mk(1,0,0,0,2'd1,3'd0,8'hA5,6'b100100);
      v[17] = mk(0,0,0,1,2'd1,3'd0,8'h02,6'b110100);
      v[18] = mk(0,0,0,0,2'd0,3'd0,8'h02,6'b110100);
      v[19] = mk(0,0,0,0,2'd0,3'd0,8'h02,6'b110100);
      v[20] = mk(0,0,0,1,2'd0,3'd0,8'h02,6'b000010);
      v[21] = mk(1,0,0,0,2'd2,3'd0,8'h34,6'b100100);
      v[22] = mk(0,0,0,1,2'd0,3'd0,8'h12,6'b110100);
      v[23] = mk(0,0,1,1,2'd0,3'd0,8'h12,6'b000000);
      v[24] = mk(0,0,0,0,2'd0,3'd0,8'h12,6'b000000);

      rst = 1'b0;
      drive(0,0,0,0,2'd0,3'd0);
      bank_data = {32'hABCD_1234, 32'hFFFF_FEA5, 32'hDEAD_BEEF};
      cyc();
      cyc();
      chk("reset", 14'h0);
      rst = 1'b1;
      cyc();
      chk("idle_after_reset", 14'h0);

      for (int i = 0; i < 25; i++) begin
         drive(v[i].st, v[i].rd, v[i].ab, v[i].rdy, v[i].sel, v[i].bs);
         cyc();
         chk($sformatf("vec%0d", i), v[i].exp);
      end

      drive(1,0,0,0,2'd0,3'd0); cyc();
      chk("ab_b0", {8'hEF, 6'b100100});
      drive(0,0,0,1,2'd0,3'd0); cyc();
      chk("ab_b1", {8'hBE, 6'b100100});
      cyc();
      chk("ab_b2", {8'hAD, 6'b100100});
      drive(0,0,1,0,2'd0,3'd0); cyc();
      chk("ab_idle", {8'hAD, 6'b000000});
      drive(1,0,0,0,2'd0,3'd0); cyc();
      chk("ab_restart", {8'hEF, 6'b100100});
      drive(0,0,0,1,2'd0,3'd0); cyc();
      chk("rst_b1", {8'hBE, 6'b100100});
      drive(0,0,0,0,2'd0,3'd0);
      rst = 1'b0;
      #1;
      chk("rst_mid", 14'h0);
      cyc();
      chk("rst_hold", 14'h0);
      rst = 1'b1;
      cyc();
      chk("rst_release", 14'h0);

      bank_data[31:0] = 32'h1122_3344;
      drive(1,0,0,0,2'd0,3'd0); cyc();
      chk("snap0", {8'h44, 6'b100100});
      bank_data[31:0] = 32'h5566_7788;
      drive(0,0,0,1,2'd0,3'd0); cyc();
      chk("snap1", {8'h33, 6'b100100});
      cyc();
      chk("snap2", {8'h22, 6'b100100});
      cyc();
      chk("snap3", {8'h11, 6'b110100});
      cyc();
      chk("snap_done", {8'h11, 6'b000010});
      drive(0,0,0,0,2'd0,3'd0); cyc();
      chk("snap_idle", {8'h11, 6'b000000});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
